// File: rtl/branch_resolve_unit.sv
// Two-stage control-flow resolver: evaluates JAL/JALR/B*, checks the fetch prediction,
// pulses flush on mispredict and trains a 2-bit bimodal history table read by fetch.
module branch_resolve_unit #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned IMM_W       = 21,
    parameter int unsigned BHT_ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [2:0]      select,
    input  logic [XLEN-1:0] pc,
    input  logic [IMM_W-1:0] imm,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] link,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic            mispredict,
    output logic            misalign,
    output logic            flush,
    input  logic [XLEN-1:0] bht_rd_pc,
    output logic            bht_rd_taken
);
    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [2:0] SEL_JAL  = 3'd0;
    localparam logic [2:0] SEL_JALR = 3'd1;
    localparam logic [2:0] SEL_BEQ  = 3'd2;
    localparam logic [2:0] SEL_BNE  = 3'd3;
    localparam logic [2:0] SEL_BLT  = 3'd4;
    localparam logic [2:0] SEL_BGE  = 3'd5;
    localparam logic [2:0] SEL_BLTU = 3'd6;
    localparam logic [2:0] SEL_BGEU = 3'd7;

    logic             s1_valid;
    logic [XLEN-1:0]  s1_op1;
    logic [XLEN-1:0]  s1_op2;
    logic [2:0]       s1_select;
    logic [XLEN-1:0]  s1_pc;
    logic [IMM_W-1:0] s1_imm;
    logic             s1_pred_taken;
    logic [XLEN-1:0]  s1_pred_target;

    logic             s2_branch;
    logic [IDX_W-1:0] s2_idx;
    logic             s1_adv;
    logic             s2_fire;

    logic [XLEN-1:0]  imm_x;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  jalr_sum;
    logic             is_jump;
    logic             cond;
    logic [XLEN-1:0]  res_target;
    logic [XLEN-1:0]  res_link;
    logic             res_misalign;
    logic             res_mispredict;

    logic [1:0]       bht [BHT_ENTRIES];
    logic             unused_rd_bits;

    assign s1_adv   = !out_valid || out_ready;
    assign s2_fire  = out_valid && out_ready;
    assign flush    = s2_fire && mispredict;
    assign in_ready = (!s1_valid || s1_adv) && !flush;

    // Resolve the op held in S1; result is registered into S2.
    always_comb begin
        imm_x    = {{(XLEN-IMM_W){s1_imm[IMM_W-1]}}, s1_imm};
        pc_plus4 = s1_pc + XLEN'(4);
        jalr_sum = s1_op1 + imm_x;
        is_jump  = (s1_select == SEL_JAL) || (s1_select == SEL_JALR);
        cond     = 1'b1;
        case (s1_select)
            SEL_BEQ:  cond = (s1_op1 == s1_op2);
            SEL_BNE:  cond = (s1_op1 != s1_op2);
            SEL_BLT:  cond = ($signed(s1_op1) <  $signed(s1_op2));
            SEL_BGE:  cond = ($signed(s1_op1) >= $signed(s1_op2));
            SEL_BLTU: cond = (s1_op1 <  s1_op2);
            SEL_BGEU: cond = (s1_op1 >= s1_op2);
            default:  cond = 1'b1;
        endcase
        if (s1_select == SEL_JALR)
            res_target = {jalr_sum[XLEN-1:1], 1'b0};
        else if (cond)
            res_target = s1_pc + imm_x;
        else
            res_target = pc_plus4;
        res_link       = is_jump ? pc_plus4 : '0;
        res_misalign   = cond && (res_target[1:0] != 2'b00);
        // A misaligned target belongs to the trap path, so it never redirects fetch here.
        res_mispredict = !res_misalign &&
                         ((cond != s1_pred_taken) || (cond && (res_target != s1_pred_target)));
    end

    // Pipeline stages S1 (captured operands) and S2 (registered result).
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            out_valid  <= 1'b0;
            link       <= '0;
            taken      <= 1'b0;
            target     <= '0;
            mispredict <= 1'b0;
            misalign   <= 1'b0;
            s2_branch  <= 1'b0;
            s2_idx     <= '0;
        end else begin
            if (flush)
                s1_valid <= 1'b0;
            else if (in_ready)
                s1_valid <= in_valid;
            if (in_ready && in_valid) begin
                s1_op1         <= op1;
                s1_op2         <= op2;
                s1_select      <= select;
                s1_pc          <= pc;
                s1_imm         <= imm;
                s1_pred_taken  <= pred_taken;
                s1_pred_target <= pred_target;
            end
            if (s1_adv) begin
                out_valid <= s1_valid && !flush;
                if (s1_valid) begin
                    link       <= res_link;
                    taken      <= cond;
                    target     <= res_target;
                    mispredict <= res_mispredict;
                    misalign   <= res_misalign;
                    s2_branch  <= !is_jump;
                    s2_idx     <= s1_pc[IDX_W+1:2];
                end
            end
        end
    end

    // Saturating 2-bit counters, trained by branches as they leave S2.
    always_ff @(posedge clk) begin
        if (rst) begin
            bht <= '{default: 2'b01};
        end else if (s2_fire && s2_branch) begin
            if (taken) begin
                if (bht[s2_idx] != 2'b11)
                    bht[s2_idx] <= bht[s2_idx] + 2'd1;
            end else if (bht[s2_idx] != 2'b00) begin
                bht[s2_idx] <= bht[s2_idx] - 2'd1;
            end
        end
    end

    assign bht_rd_taken   = bht[bht_rd_pc[IDX_W+1:2]][1];
    assign unused_rd_bits = ^{bht_rd_pc[XLEN-1:IDX_W+2], bht_rd_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a driver pushes reference-model results,
// a negedge monitor compares every presented output and tracks the history table.
module tb_branch_resolve_unit;
    localparam int unsigned XLEN        = 64;
    localparam int unsigned IMM_W       = 21;
    localparam int unsigned BHT_ENTRIES = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] op1, op2, pc, pred_target, bht_rd_pc;
    logic [2:0]      select;
    logic [IMM_W-1:0] imm;
    logic            pred_taken;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] link, target;
    logic            taken, mispredict, misalign, flush, bht_rd_taken;

    branch_resolve_unit #(.XLEN(XLEN), .IMM_W(IMM_W), .BHT_ENTRIES(BHT_ENTRIES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .select(select), .pc(pc), .imm(imm),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .out_valid(out_valid), .out_ready(out_ready), .link(link), .taken(taken),
        .target(target), .mispredict(mispredict), .misalign(misalign), .flush(flush),
        .bht_rd_pc(bht_rd_pc), .bht_rd_taken(bht_rd_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] op1, op2, pc, pred_target;
        logic [2:0]  sel;
        logic [20:0] imm;
        logic        pred_taken;
    } op_t;

    typedef struct {
        logic [63:0] link, target, pc;
        logic        taken, mispredict, misalign, is_branch;
    } exp_t;

    exp_t exp_q[$];
    int   bht_m[BHT_ENTRIES];
    int   checks = 0;
    int   passed = 0;
    int   dropped = 0;
    logic hold_low = 1'b0;
    logic rand_ready = 1'b0;
    logic saw_stall = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Reference resolution straight from the instruction semantics.
    function automatic exp_t model(input op_t o);
        exp_t e;
        logic [63:0] sx;
        logic c;
        sx = {{43{o.imm[20]}}, o.imm};
        c = 1'b0;
        case (o.sel)
            3'd0, 3'd1: c = 1'b1;
            3'd2: c = (o.op1 == o.op2);
            3'd3: c = (o.op1 != o.op2);
            3'd4: c = ($signed(o.op1) <  $signed(o.op2));
            3'd5: c = ($signed(o.op1) >= $signed(o.op2));
            3'd6: c = (o.op1 <  o.op2);
            default: c = (o.op1 >= o.op2);
        endcase
        e.pc        = o.pc;
        e.is_branch = (o.sel >= 3'd2);
        e.link      = (o.sel < 3'd2) ? o.pc + 64'd4 : 64'd0;
        e.taken     = c;
        if (o.sel == 3'd1) e.target = (o.op1 + sx) & ~64'd1;
        else               e.target = c ? o.pc + sx : o.pc + 64'd4;
        e.misalign   = c && (e.target[1:0] != 2'b00);
        e.mispredict = !e.misalign && ((c != o.pred_taken) || (c && (e.target != o.pred_target)));
        return e;
    endfunction

    function automatic int bht_idx(input logic [63:0] a);
        return int'((a >> 2) % 64'(BHT_ENTRIES));
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = hold_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    // Monitor: compare presented output against the oldest expectation every cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            check("bht_rd_taken", 64'(bht_rd_taken), 64'(bht_m[bht_idx(bht_rd_pc)] >= 2));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_out: out_valid=1 target=0x%0h, expected no output", target);
                end else begin
                    e = exp_q[0];
                    check("taken", 64'(taken), 64'(e.taken));
                    check("target", target, e.target);
                    check("link", link, e.link);
                    check("mispredict", 64'(mispredict), 64'(e.mispredict));
                    check("misalign", 64'(misalign), 64'(e.misalign));
                    check("flush", 64'(flush), 64'(out_ready && e.mispredict));
                    if (out_ready) begin
                        e = exp_q.pop_front();
                        if (e.is_branch) begin
                            if (e.taken) bht_m[bht_idx(e.pc)] = (bht_m[bht_idx(e.pc)] == 3) ? 3 : bht_m[bht_idx(e.pc)] + 1;
                            else         bht_m[bht_idx(e.pc)] = (bht_m[bht_idx(e.pc)] == 0) ? 0 : bht_m[bht_idx(e.pc)] - 1;
                        end
                        // A redirect kills every younger op still in flight.
                        if (e.mispredict) begin
                            dropped += exp_q.size();
                            exp_q.delete();
                        end
                    end
                end
            end else begin
                check("flush_idle", 64'(flush), 64'd0);
            end
            if (flush) check("in_ready_during_flush", 64'(in_ready), 64'd0);
        end
    end

    task automatic send(input op_t o, input logic [63:0] rd_pc);
        int waitc;
        waitc = 0;
        in_valid = 1'b1;
        op1 = o.op1; op2 = o.op2; select = o.sel; pc = o.pc; imm = o.imm;
        pred_taken = o.pred_taken; pred_target = o.pred_target; bht_rd_pc = rd_pc;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(o));
                break;
            end
            saw_stall = 1'b1;
            waitc++;
            if (waitc > 200) begin
                checks++;
                $display("FAIL accept_timeout: in_ready stuck 0, expected 1 within 200 cycles");
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || out_valid) && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (c >= 200) begin
            checks++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    function automatic op_t mk(input logic [2:0] s, input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] p, input logic [20:0] i,
                               input logic pt, input logic [63:0] ptg);
        op_t o;
        o.sel = s; o.op1 = a; o.op2 = b; o.pc = p; o.imm = i;
        o.pred_taken = pt; o.pred_target = ptg;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        exp_t e;
        o.sel = 3'($urandom_range(0, 7));
        o.op1 = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) o.op1 = o.op1 & ~64'd3;
        case ($urandom_range(0, 2))
            0: o.op2 = o.op1;
            1: o.op2 = {$urandom, $urandom};
            default: o.op2 = 64'($urandom_range(0, 8)) - 64'd4;
        endcase
        o.pc  = 64'($urandom_range(0, 255)) << 2;
        o.imm = 21'($urandom);
        if ($urandom_range(0, 3) != 0) o.imm = o.imm & ~21'd3;
        o.pred_taken  = 1'($urandom_range(0, 1));
        o.pred_target = {$urandom, $urandom};
        e = model(o);
        if ($urandom_range(0, 1) == 1) o.pred_target = e.target;
        return o;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0;
        op1 = '0; op2 = '0; select = '0; pc = '0; imm = '0;
        pred_taken = 1'b0; pred_target = '0; bht_rd_pc = '0;
        foreach (bht_m[i]) bht_m[i] = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
            bht_rd_pc = 64'(i) << 2;
            #1 check("reset_bht", 64'(bht_rd_taken), 64'd0);
        end
        @(posedge clk); #1;

        // Correctly predicted BGE on equal negative operands
        send(mk(3'd5, '1, '1, 64'h100, 21'h40, 1'b1, 64'h140), 64'h100);
        drain();
        // BLTU mispredict with a younger op right behind it
        send(mk(3'd6, 64'd1, '1, 64'h200, 21'h20, 1'b0, 64'h204), 64'h200);
        send(mk(3'd2, 64'd7, 64'd7, 64'h300, 21'h10, 1'b1, 64'h310), 64'h300);
        drain();
        check("younger_op_dropped", 64'(dropped), 64'd1);
        // Misaligned JALR
        send(mk(3'd1, 64'h1003, 64'd0, 64'h80, 21'h0, 1'b1, 64'h0), 64'h80);
        drain();
        // Three taken BEQs saturate the counter at one index
        for (int i = 0; i < 3; i++) begin
            send(mk(3'd2, 64'd5, 64'd5, 64'h10, 21'h8, 1'b1, 64'h18), 64'h10);
            drain();
        end
        check("bht_saturated_taken", 64'(bht_rd_taken), 64'd1);

        // Backpressure: four ops with the consumer stalled
        saw_stall = 1'b0;
        hold_low = 1'b1;
        fork
            for (int i = 0; i < 4; i++)
                send(mk(3'd0, 64'd0, 64'd0, 64'h400 + 64'(i * 16), 21'h100, 1'b1,
                        64'h500 + 64'(i * 16)), 64'h400);
            begin
                repeat (4) @(posedge clk);
                hold_low = 1'b0;
            end
        join
        drain();
        check("backpressure_stall", 64'(saw_stall), 64'd1);

        // Reset with ops in flight discards both stages and the trained table
        send(mk(3'd2, 64'd1, 64'd1, 64'h10, 21'h8, 1'b1, 64'h18), 64'h10);
        send(mk(3'd3, 64'd1, 64'd2, 64'h20, 21'h8, 1'b1, 64'h28), 64'h10);
        rst = 1'b1;
        exp_q.delete();
        foreach (bht_m[i]) bht_m[i] = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        check("midreset_bht", 64'(bht_rd_taken), 64'd0);
        @(posedge clk); #1;

        // Randomised traffic with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            send(rand_op(), 64'($urandom_range(0, 255)) << 2);
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk); #1;
            end
        end
        rand_ready = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
